// File: rtl/count_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// count_ctrl_pkg
//
// Shared definitions for the LED counter run/direction sequencer:
//   - state_e : sequencer state encoding (PAUSED / RUN_UP / RUN_DOWN)
//   - mode_e  : counting mode (MANUAL / BOUNCE)
//   - DB_CYCLES_DEFAULT : default debounce stability window (5 ms at 10 MHz)
//   - run_state() : maps a direction bit onto the matching RUN_* state
// -----------------------------------------------------------------------------
package count_ctrl_pkg;

    typedef enum logic [1:0] {
        PAUSED   = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2
    } state_e;

    typedef enum logic {
        MANUAL = 1'b0,
        BOUNCE = 1'b1
    } mode_e;

    localparam int DB_CYCLES_DEFAULT = 50000;

    // 1 = up, 0 = down
    function automatic state_e run_state(input logic up);
        return up ? RUN_UP : RUN_DOWN;
    endfunction

endpackage

// File: rtl/debounce.sv
// -----------------------------------------------------------------------------
// debounce
//
// Two-flop synchroniser followed by a stability-counter debouncer and a
// rising-edge press detector for one raw board input.
//
// Parameters:
//   DB_CYCLES : consecutive cycles the synchronised input must differ from the
//               current debounced level before that level changes.
// Ports:
//   clk    in  : system clock
//   rst    in  : asynchronous reset, active low
//   raw_in in  : raw switch / button
//   level  out : debounced level (registered)
//   press  out : one-cycle pulse, registered, in the cycle the debounced
//                level rises
// Latency: raw edge to level/press change is 2 + DB_CYCLES clock edges.
// -----------------------------------------------------------------------------
module debounce
    import count_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic level,
    output logic press
);

    // Counter only ever needs to reach DB_CYCLES-1; +1 keeps width >= 1.
    localparam int                CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        // Any cycle where the input agrees with the current level restarts
        // the stability window, so short glitches never get through.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/count_ctrl.sv
// -----------------------------------------------------------------------------
// count_ctrl
//
// Run/pause and direction sequencer for the LED counter. Converts divider
// ticks into gated do_count pulses, chooses the step direction, and offers a
// run/pause button plus an optional ping-pong (BOUNCE) mode.
//
// Build option:
//   COUNT_CTRL_BOUNCE_EN : when defined, BOUNCE mode and the btn_mode path are
//                          built. When undefined, btn_mode is ignored, its
//                          debouncer is absent, mode_bounce is 0 and the block
//                          runs MANUAL only.
//
// Parameters:
//   DB_CYCLES : debounce stability window in cycles
//   WIDTH     : counter width
// Ports:
//   clk         in  : system clock
//   rst         in  : asynchronous reset, active low
//   tick        in  : one-cycle pulse from the divider
//   sw_dir      in  : raw direction switch, 1 = up
//   btn_run     in  : raw run/pause button, 1 = pressed
//   btn_mode    in  : raw mode button, 1 = pressed
//   count       in  : current counter value (feedback)
//   do_count    out : step pulse to the counter (cycle after the tick)
//   increment   out : step direction, 1 = up; holds between steps
//   running     out : 1 unless PAUSED
//   mode_bounce out : 1 while BOUNCE mode is active
// -----------------------------------------------------------------------------
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int WIDTH     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             sw_dir,
    input  logic             btn_run,
    input  logic             btn_mode,
    input  logic [WIDTH-1:0] count,
    output logic             do_count,
    output logic             increment,
    output logic             running,
    output logic             mode_bounce
);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic dir_level;
    logic dir_press_unused;
    logic run_press;
    logic run_level_unused;
    logic mode_press;
    logic at_max;
    logic at_zero;

    debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dir (
        .clk    (clk),
        .rst    (rst),
        .raw_in (sw_dir),
        .level  (dir_level),
        .press  (dir_press_unused)
    );

    debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
        .clk    (clk),
        .rst    (rst),
        .raw_in (btn_run),
        .level  (run_level_unused),
        .press  (run_press)
    );

`ifdef COUNT_CTRL_BOUNCE_EN
    logic mode_level_unused;

    debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .clk    (clk),
        .rst    (rst),
        .raw_in (btn_mode),
        .level  (mode_level_unused),
        .press  (mode_press)
    );

    // End-of-range detection for the bounce reversal.
    assign at_max  = &count;
    assign at_zero = ~|count;
`else
    // MANUAL-only build: mode button and counter feedback have no function.
    logic inputs_unused;
    assign inputs_unused = ^{btn_mode, count};
    assign mode_press    = 1'b0;
    assign at_max        = 1'b0;
    assign at_zero       = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_e state_q,   state_d;
    mode_e  mode_q,    mode_d;
    logic   last_up_q, last_up_d;       // direction to resume with in BOUNCE
    logic   do_count_q,  do_count_d;
    logic   increment_q, increment_d;
    logic   running_q,   running_d;
    logic   step_up;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        last_up_d   = last_up_q;
        do_count_d  = 1'b0;
        increment_d = increment_q;
        step_up     = (state_q == RUN_UP);

        // Bounce reversal is decided on the count sampled in the tick cycle,
        // so the step issued at an end stop already heads back inwards.
        if (mode_q == BOUNCE) begin
            if (state_q == RUN_UP && at_max) begin
                step_up = 1'b0;
            end else if (state_q == RUN_DOWN && at_zero) begin
                step_up = 1'b1;
            end
        end

        // A run press in the tick cycle swallows the step either way.
        if (tick && !run_press && state_q != PAUSED) begin
            do_count_d  = 1'b1;
            increment_d = step_up;
            if (mode_q == BOUNCE) begin
                state_d = run_state(step_up);
            end
        end

        // Mode decisions below use mode_q, so a mode press in this cycle
        // only takes effect from the next one.
        if (run_press) begin
            if (state_q == PAUSED) begin
                state_d = run_state((mode_q == BOUNCE) ? last_up_q : dir_level);
            end else begin
                state_d = PAUSED;
            end
        end else if (state_q != PAUSED && mode_q == MANUAL) begin
            // In MANUAL the running direction simply tracks the switch; this
            // also re-derives it the cycle after leaving BOUNCE.
            state_d = run_state(dir_level);
        end

        if (state_d != PAUSED) begin
            last_up_d = (state_d == RUN_UP);
        end

        if (mode_press) begin
            mode_d = (mode_q == MANUAL) ? BOUNCE : MANUAL;
        end

        running_d = (state_d != PAUSED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= PAUSED;
            mode_q      <= MANUAL;
            last_up_q   <= 1'b1;
            do_count_q  <= 1'b0;
            increment_q <= 1'b1;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            last_up_q   <= last_up_d;
            do_count_q  <= do_count_d;
            increment_q <= increment_d;
            running_q   <= running_d;
        end
    end

    assign do_count  = do_count_q;
    assign increment = increment_q;
    assign running   = running_q;

`ifdef COUNT_CTRL_BOUNCE_EN
    assign mode_bounce = (mode_q == BOUNCE);
`else
    assign mode_bounce = 1'b0;
`endif

endmodule

// File: tb/tb_count_ctrl.sv
// -----------------------------------------------------------------------------
// tb_count_ctrl
//
// Self-checking bench for count_ctrl with DB_CYCLES = 4. A behavioural model
// derives debounced levels from a window over the recorded raw input history
// and tracks run/direction/mode as plain bits; DUT outputs are compared with
// it every cycle, #1 after the rising edge.
// -----------------------------------------------------------------------------
module tb_count_ctrl;

    localparam int DB    = 4;
    localparam int HMAX  = 8192;
`ifdef COUNT_CTRL_BOUNCE_EN
    localparam bit BOUNCE_BUILT = 1'b1;
`else
    localparam bit BOUNCE_BUILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       sw_dir;
    logic       btn_run;
    logic       btn_mode;
    logic [7:0] count;
    logic       do_count;
    logic       increment;
    logic       running;
    logic       mode_bounce;

    count_ctrl #(.DB_CYCLES(DB), .WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .sw_dir      (sw_dir),
        .btn_run     (btn_run),
        .btn_mode    (btn_mode),
        .count       (count),
        .do_count    (do_count),
        .increment   (increment),
        .running     (running),
        .mode_bounce (mode_bounce)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    bit hist [3][HMAX];          // raw samples per edge since reset: 0=dir 1=run 2=mode
    int k;                       // edge index since reset release
    bit m_db    [3];             // debounced levels after the last edge
    bit m_pulse [3];             // press pulses after the last edge
    bit m_running, m_up, m_last_up, m_bounce;
    bit exp_do, exp_inc;
    int since_tick;

    function automatic bit rawv(input int ch, input int i);
        if (i < 0 || i >= HMAX) return 1'b0;
        return hist[ch][i];
    endfunction

    task automatic model_reset();
        k = 0;
        for (int ch = 0; ch < 3; ch++) begin
            m_db[ch]    = 1'b0;
            m_pulse[ch] = 1'b0;
        end
        m_running  = 1'b0;
        m_up       = 1'b1;
        m_last_up  = 1'b1;
        m_bounce   = 1'b0;
        exp_do     = 1'b0;
        exp_inc    = 1'b1;
        since_tick = 99;
    endtask

    // One clock: drive inputs at the falling edge, advance the model over the
    // rising edge, then compare.
    task automatic step_cycle(input bit t, input bit sd, input bit br, input bit bm, input bit [7:0] c);
        bit run_p, mode_p, up, v0, stable;
        @(negedge clk);
        rst      = 1'b1;
        tick     = t;
        sw_dir   = sd;
        btn_run  = br;
        btn_mode = bm;
        count    = c;
        if (k < HMAX) begin
            hist[0][k] = sd;
            hist[1][k] = br;
            hist[2][k] = bm;
        end
        since_tick = t ? 0 : since_tick + 1;
        @(posedge clk);
        #1;
        run_p  = m_pulse[1];
        mode_p = BOUNCE_BUILT && m_pulse[2];
        exp_do = 1'b0;
        if (t && m_running && !run_p) begin
            up = m_up;
            if (m_bounce) begin
                if (up && c == 8'hFF)       up = 1'b0;
                else if (!up && c == 8'h00) up = 1'b1;
            end
            exp_do  = 1'b1;
            exp_inc = up;
            m_up    = up;
        end
        if (run_p) begin
            if (!m_running) begin
                m_running = 1'b1;
                m_up      = m_bounce ? m_last_up : m_db[0];
            end else begin
                m_running = 1'b0;
            end
        end else if (m_running && !m_bounce) begin
            m_up = m_db[0];
        end
        if (m_running) m_last_up = m_up;
        if (mode_p)    m_bounce = !m_bounce;
        // A debounced level follows the raw input once the synchronised copy
        // has held a new value for DB whole cycles.
        for (int ch = 0; ch < 3; ch++) begin
            v0     = rawv(ch, k - DB - 1);
            stable = 1'b1;
            for (int j = k - DB; j <= k - 2; j++) begin
                if (rawv(ch, j) != v0) stable = 1'b0;
            end
            m_pulse[ch] = 1'b0;
            if (stable && v0 != m_db[ch]) begin
                m_db[ch]    = v0;
                m_pulse[ch] = v0;
            end
        end
        k++;
        check_eq("do_count",    {31'd0, do_count},    {31'd0, exp_do});
        check_eq("increment",   {31'd0, increment},   {31'd0, exp_inc});
        check_eq("running",     {31'd0, running},     {31'd0, m_running});
        check_eq("mode_bounce", {31'd0, mode_bounce}, {31'd0, m_bounce});
    endtask

    // Reset held for n cycles with random inputs; released by the next step_cycle.
    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_do_count",  {31'd0, do_count},    32'd0);
        check_eq("rst_increment", {31'd0, increment},   32'd1);
        check_eq("rst_running",   {31'd0, running},     32'd0);
        check_eq("rst_mode",      {31'd0, mode_bounce}, 32'd0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick     = 1'($urandom);
            sw_dir   = 1'($urandom);
            btn_run  = 1'($urandom);
            btn_mode = 1'($urandom);
            count    = 8'($urandom);
            @(posedge clk);
            #1;
            check_eq("rst_hold_do",  {31'd0, do_count},  32'd0);
            check_eq("rst_hold_inc", {31'd0, increment}, 32'd1);
            check_eq("rst_hold_run", {31'd0, running},   32'd0);
        end
        model_reset();
    endtask

    // n cycles with constant raw inputs; ticks every tper cycles (0 = none).
    task automatic drive(input int n, input bit sd, input bit br, input bit bm,
                         input int tper, input bit fixed_c, input bit [7:0] cval);
        bit t;
        for (int i = 0; i < n; i++) begin
            t = (tper > 0) && ((i % tper) == tper - 1);
            step_cycle(t, sd, br, bm, fixed_c ? cval : 8'($urandom));
        end
    endtask

    function automatic bit [7:0] rand_count();
        case ($urandom_range(2, 0))
            0:       return 8'hFF;
            1:       return 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic random_phase(input int n);
        bit sd, br, bm, t;
        sd = 1'b0; br = 1'b0; bm = 1'b0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(11, 0) == 0) sd = !sd;
            if ($urandom_range(9, 0) == 0)  br = !br;
            if ($urandom_range(13, 0) == 0) bm = !bm;
            t = 1'b0;
            if (since_tick >= 1) begin
                // Line ticks up with model-predicted press pulses to hit the
                // simultaneous-event rules often.
                if ((m_pulse[1] || m_pulse[2]) && $urandom_range(1, 0) == 0) t = 1'b1;
                else if ($urandom_range(2, 0) == 0)                          t = 1'b1;
            end
            step_cycle(t, sd, br, bm, rand_count());
        end
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; sw_dir = 1'b0; btn_run = 1'b0; btn_mode = 1'b0; count = 8'h00;
        model_reset();

        // Reset, then ticks while paused.
        do_reset(5);
        drive(6, 1'b0, 1'b0, 1'b0, 2, 1'b0, 8'h00);

        // Manual run up with ticks.
        drive(10, 1'b1, 1'b1, 1'b0, 0, 1'b0, 8'h00);
        drive(22, 1'b1, 1'b0, 1'b0, 10, 1'b0, 8'h00);

        // Direction change at count 00 (wraps downward).
        drive(14, 1'b0, 1'b0, 1'b0, 4, 1'b1, 8'h00);

        // Run button chatter: toggles too fast to register.
        for (int i = 0; i < 10; i++) drive(2, 1'b0, 1'(i % 2), 1'b0, 0, 1'b0, 8'h00);
        drive(6, 1'b0, 1'b0, 1'b0, 3, 1'b0, 8'h00);

        // Pause.
        drive(10, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h00);
        drive(6, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00);

        // Bounce: mode press, run press, end stops at FF and 00.
        drive(10, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'h00);
        drive(4,  1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00);
        drive(10, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h00);
        drive(6,  1'b0, 1'b0, 1'b0, 3, 1'b1, 8'hFF);
        drive(6,  1'b0, 1'b0, 1'b0, 3, 1'b1, 8'h00);
        drive(6,  1'b0, 1'b0, 1'b0, 3, 1'b1, 8'h42);

        // Randomised run with a reset in the middle of operation.
        random_phase(1200);
        do_reset(3);
        random_phase(1200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/count_ctrl.md
# count_ctrl

Run/pause and direction sequencer for the 8-bit LED counter. Sits between the tick divider and the counter: turns divider ticks into gated `do_count` pulses, picks the counting direction, and provides a run/pause button and an optional ping-pong (bounce) mode. Raw board switches and buttons are synchronised and debounced inside the block.

## Interface

- `DB_CYCLES`, 50000: consecutive stable cycles required before a debounced input changes (5 ms at 10 MHz).
- `WIDTH`, 8: counter width.

- `clk`  in  1: system clock (gclk10 domain).
- `rst`  in  1: reset, asynchronous, active-low (0 = reset).
- `tick`  in  1: one-cycle pulse from the divider.
- `sw_dir`  in  1: raw direction switch, 1 = up.
- `btn_run`  in  1: raw run/pause button, 1 = pressed.
- `btn_mode`  in  1: raw mode button, 1 = pressed.
- `count`  in  WIDTH: current counter value (feedback).
- `do_count`  out  1: step pulse to the counter.
- `increment`  out  1: step direction, 1 = up.
- `running`  out  1: 1 unless the state is PAUSED.
- `mode_bounce`  out  1: 1 when bounce mode is active.

## Operation

- Inputs pass through a 2-flop synchroniser and then a debouncer. The debouncer output takes the new value only after it has been stable and different for DB_CYCLES consecutive cycles. A rising edge of a debounced button produces a one-cycle press pulse.
- States: PAUSED, RUN_UP, RUN_DOWN. Modes: MANUAL, BOUNCE.
- Run press:
  - PAUSED → RUN_UP or RUN_DOWN. In MANUAL the direction comes from the debounced `sw_dir`. In BOUNCE it is the last run direction (UP after reset).
  - RUN_* → PAUSED.
- Mode press toggles the mode in any state. Entering MANUAL while running re-derives the direction from `sw_dir` on the next cycle.
- MANUAL while running: a debounced `sw_dir` change switches between RUN_UP and RUN_DOWN. The counter wraps naturally (FF→00, 00→FF).
- BOUNCE: `sw_dir` is ignored. On a tick, RUN_UP with `count`==all-ones moves to RUN_DOWN and the step issued is down (FF→FE). RUN_DOWN with `count`==0 moves to RUN_UP and the step issued is up (00→01). The counter never wraps in BOUNCE.
- Step rule: a tick in a RUN state produces one `do_count` pulse, with `increment` set to the direction after any bounce reversal.
- Simultaneous events:
  - A run press in the same cycle as a tick always suppresses that step, whether pausing or resuming.
  - A mode press in the same cycle as a tick leaves that step under the old mode.

## Timing

- Reset values: `do_count`=0, `increment`=1, `running`=0, `mode_bounce`=0. State is PAUSED, mode is MANUAL, debouncers hold 0, last direction is UP.
- All outputs are registered. A tick in cycle N gives `do_count`=1 in cycle N+1 only.
- `increment` is valid whenever `do_count`=1 and holds its last value otherwise.
- Button latency: raw edge to press pulse is 2 (sync) + DB_CYCLES cycles. The state change appears on `running` one cycle after the pulse.
- Assertion of `rst` mid-operation forces the reset values immediately. Any `do_count` pulse in flight is dropped.
- `count` is sampled in the tick cycle. The counter updates `count` one cycle after `do_count`, so consecutive ticks must be ≥2 cycles apart; the divider guarantees this.

## Configuration

- `COUNT_CTRL_BOUNCE_EN` defined: BOUNCE mode and the `btn_mode` path are built as described.
- Not defined:
  - `btn_mode` is ignored and its debouncer is not instantiated.
  - `mode_bounce` is tied to 0.
  - Behaviour is MANUAL only.

## Structure

- Shared package `count_ctrl_pkg` holds:
  - the state encoding (PAUSED=2'd0, RUN_UP=2'd1, RUN_DOWN=2'd2);
  - the mode encoding;
  - the default DB_CYCLES constant.
- Sub-module `debounce` contains the synchroniser, the stability counter and the rising-edge pulse. It is instantiated once per raw input.
- The FSM and the step logic live in `count_ctrl`.

## Test plan

All scenarios use DB_CYCLES=4.

- **Reset:** hold `rst`=0 with random inputs → outputs are 0/1/0/0. Release, then send 3 ticks → no `do_count`.
- **Manual run up:** `sw_dir`=1, press run, send ticks at cycles 20 and 30 → `do_count` at 21 and 31 with `increment`=1, `running`=1.
- **Direction change and wrap:** `count`=8'h00, flip `sw_dir` to 0 and wait 6 cycles, then tick → `do_count`=1, `increment`=0 (counter goes to FF).
- **Bounce:** define the macro, press mode and then run, present `count`=8'hFF with a tick → `increment`=0. Present `count`=8'h00 with a tick → `increment`=1.
- **Collision:** a run-press pulse in the same cycle as a tick while in RUN_UP → no `do_count`, `running`=0 next cycle.
- **Bounce filtering:** toggle `btn_run` every 2 cycles for 20 cycles → no press pulse and no state change.
